key_debounce: RTL and testbench

Debounces one raw mechanical key input (active-low, idle high) and produces a clean level plus a one-cycle change strobe.
Sits directly upstream of the key-driven edge/toggle stages (e.g. LED/buzzer toggle). Those stages take key_value as their debounced input pin.
A 4-state FSM with a stability counter qualifies each transition.

---
 rtl/key_debounce.sv | 137 +++++++++++++
 tb/tb_key_debounce.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/key_debounce.sv
`default_nettype none
// ============================================================================
// Module   : key_debounce
// Brief    : Two-flop synchroniser plus 4-state filter FSM that debounces an
//            active-low key into a clean level and a one-cycle change strobe.
//            Define KEY_LONG_PRESS_EN to add the long_flag long-press pulse.
// Revision : 1.0 - initial release
// ============================================================================
module key_debounce #(
    parameter int DEBOUNCE_CNT = 1_000_000
`ifdef KEY_LONG_PRESS_EN
    ,
    parameter int LONG_CNT     = 50_000_000
`endif
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_in,
    output logic key_value,
    output logic key_flag
`ifdef KEY_LONG_PRESS_EN
    ,
    output logic long_flag
`endif
);

    localparam int c_cnt_w = $clog2(DEBOUNCE_CNT);
    // The entry edge is the first stable sample, so DEBOUNCE_CNT samples are
    // complete when the counter reads DEBOUNCE_CNT-2.
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEBOUNCE_CNT - 2);

    typedef enum logic [1:0] {
        IDLE_UP     = 2'd0,
        FILTER_DOWN = 2'd1,
        HELD_DOWN   = 2'd2,
        FILTER_UP   = 2'd3
    } state_t;

    state_t               r_state;
    logic                 r_sync0;
    logic                 r_sync1;
    logic [c_cnt_w-1:0]   r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync0   <= 1'b1;
            r_sync1   <= 1'b1;
            r_state   <= IDLE_UP;
            r_cnt     <= '0;
            key_value <= 1'b1;
            key_flag  <= 1'b0;
        end else begin
            r_sync0  <= key_in;
            r_sync1  <= r_sync0;
            key_flag <= 1'b0;
            case (r_state)
                IDLE_UP: begin
                    if (!r_sync1) begin
                        r_state <= FILTER_DOWN;
                        r_cnt   <= '0;
                    end
                end
                FILTER_DOWN: begin
                    if (r_sync1) begin
                        r_state <= IDLE_UP;
                        r_cnt   <= '0;
                    end else if (r_cnt == c_cnt_last) begin
                        r_state   <= HELD_DOWN;
                        r_cnt     <= '0;
                        key_value <= 1'b0;
                        key_flag  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                HELD_DOWN: begin
                    if (r_sync1) begin
                        r_state <= FILTER_UP;
                        r_cnt   <= '0;
                    end
                end
                FILTER_UP: begin
                    if (!r_sync1) begin
                        r_state <= HELD_DOWN;
                        r_cnt   <= '0;
                    end else if (r_cnt == c_cnt_last) begin
                        r_state   <= IDLE_UP;
                        r_cnt     <= '0;
                        key_value <= 1'b1;
                        key_flag  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state   <= IDLE_UP;
                    r_cnt     <= '0;
                    key_value <= 1'b1;
                    key_flag  <= 1'b0;
                end
            endcase
        end
    end

`ifdef KEY_LONG_PRESS_EN
    localparam int c_lcnt_w = $clog2(LONG_CNT);
    localparam logic [c_lcnt_w-1:0] c_lcnt_last = c_lcnt_w'(LONG_CNT - 1);

    logic [c_lcnt_w-1:0] r_lcnt;
    logic                r_long_done;

    // Press time keeps accumulating through release bounces (FILTER_UP) and
    // only restarts once the key is back in an unpressed state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lcnt      <= '0;
            r_long_done <= 1'b0;
            long_flag   <= 1'b0;
        end else begin
            long_flag <= 1'b0;
            if (r_state == HELD_DOWN || r_state == FILTER_UP) begin
                if (r_lcnt != c_lcnt_last) begin
                    r_lcnt <= r_lcnt + 1'b1;
                end else if (!r_long_done) begin
                    long_flag   <= 1'b1;
                    r_long_done <= 1'b1;
                end
            end else begin
                r_lcnt      <= '0;
                r_long_done <= 1'b0;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_key_debounce.sv
`default_nettype none
// Directed bench for key_debounce with DEBOUNCE_CNT=8 (10-edge latency) and,
// when KEY_LONG_PRESS_EN is defined, LONG_CNT=20.
module tb_key_debounce;

    logic clk = 1'b0;
    logic rst_n;
    logic key_in;
    logic key_value;
    logic key_flag;
`ifdef KEY_LONG_PRESS_EN
    logic long_flag;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    key_debounce #(
        .DEBOUNCE_CNT(8)
`ifdef KEY_LONG_PRESS_EN
        ,
        .LONG_CNT(20)
`endif
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .key_in   (key_in),
        .key_value(key_value),
        .key_flag (key_flag)
`ifdef KEY_LONG_PRESS_EN
        ,
        .long_flag(long_flag)
`endif
    );

    typedef struct {
        logic key;
        int   cycles;
        logic exp_value;
        int   exp_flags;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Apply one level for n edges and count key_flag pulses seen.
    task automatic run(input logic k, input int n, output int flags);
        key_in = k;
        flags  = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (key_flag) flags++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int f;
        int ftot;
        vecs[0]  = '{1'b1, 5,  1'b1, 0};
        vecs[1]  = '{1'b0, 9,  1'b1, 0};
        vecs[2]  = '{1'b0, 1,  1'b0, 1};
        vecs[3]  = '{1'b0, 20, 1'b0, 0};
        vecs[4]  = '{1'b1, 9,  1'b0, 0};
        vecs[5]  = '{1'b1, 1,  1'b1, 1};
        vecs[6]  = '{1'b0, 5,  1'b1, 0};
        vecs[7]  = '{1'b1, 15, 1'b1, 0};
        vecs[8]  = '{1'b0, 7,  1'b1, 0};
        vecs[9]  = '{1'b1, 12, 1'b1, 0};
        vecs[10] = '{1'b0, 8,  1'b1, 0};
        vecs[11] = '{1'b1, 2,  1'b0, 1};
        vecs[12] = '{1'b1, 7,  1'b0, 0};
        vecs[13] = '{1'b1, 1,  1'b1, 1};
        vecs[14] = '{1'b1, 5,  1'b1, 0};

        rst_n  = 1'b0;
        key_in = 1'b1;
        repeat (3) tick();
        check("reset key_value", key_value, 1'b1);
        check("reset key_flag", key_flag, 1'b0);
`ifdef KEY_LONG_PRESS_EN
        check("reset long_flag", long_flag, 1'b0);
`endif
        rst_n = 1'b1;

        for (int r = 0; r < 15; r++) begin
            run(vecs[r].key, vecs[r].cycles, f);
            check($sformatf("vec%0d key_value", r), key_value, vecs[r].exp_value);
            check($sformatf("vec%0d flags", r), f, vecs[r].exp_flags);
        end

        // Bouncing press: 3-cycle lows/highs never qualify.
        ftot = 0;
        for (int p = 0; p < 3; p++) begin
            run(1'b0, 3, f); ftot += f;
            run(1'b1, 3, f); ftot += f;
        end
        check("bounce press value", key_value, 1'b1);
        check("bounce press flags", ftot, 0);
        run(1'b0, 9, f);
        check("bounce settle pre value", key_value, 1'b1);
        check("bounce settle pre flags", f, 0);
        run(1'b0, 1, f);
        check("bounce settle value", key_value, 1'b0);
        check("bounce settle flag", f, 1);
        run(1'b0, 10, f);
        ftot = f;
        for (int p = 0; p < 2; p++) begin
            run(1'b1, 3, f); ftot += f;
            run(1'b0, 3, f); ftot += f;
        end
        check("bounce release value", key_value, 1'b0);
        check("bounce release flags", ftot, 0);
        run(1'b1, 9, f);
        check("release pre value", key_value, 1'b0);
        check("release pre flags", f, 0);
        run(1'b1, 1, f);
        check("release value", key_value, 1'b1);
        check("release flag", f, 1);
        run(1'b1, 5, f);

        // Reset while filtering a press (cnt=5 after 8 edges).
        run(1'b0, 8, f);
        rst_n = 1'b0;
        #2;
        check("rst in filter value", key_value, 1'b1);
        check("rst in filter flag", key_flag, 1'b0);
        tick();
        rst_n = 1'b1;
        run(1'b0, 9, f);
        check("post-rst pre value", key_value, 1'b1);
        check("post-rst pre flags", f, 0);
        run(1'b0, 1, f);
        check("post-rst value", key_value, 1'b0);
        check("post-rst flag", f, 1);

        // Reset while held: output returns high at once, no flag on release.
        rst_n = 1'b0;
        #2;
        check("rst in held value", key_value, 1'b1);
        check("rst in held flag", key_flag, 1'b0);
        key_in = 1'b1;
        tick();
        rst_n = 1'b1;
        run(1'b1, 12, f);
        check("after held rst value", key_value, 1'b1);
        check("after held rst flags", f, 0);

`ifdef KEY_LONG_PRESS_EN
        begin
            int kf_at;
            int lf_at;
            int lf_n;
            // Steady 60-cycle hold.
            kf_at = -1; lf_at = -1; lf_n = 0;
            key_in = 1'b0;
            for (int i = 1; i <= 60; i++) begin
                tick();
                if (key_flag) kf_at = i;
                if (long_flag) begin lf_at = i; lf_n++; end
            end
            check("long key_flag edge", kf_at, 10);
            check("long_flag edge", lf_at, 30);
            check("long_flag count", lf_n, 1);
            lf_n = 0;
            key_in = 1'b1;
            for (int i = 0; i < 15; i++) begin
                tick();
                if (long_flag) lf_n++;
            end
            check("long release no pulse", lf_n, 0);

            // 15-cycle hold: no long press.
            lf_n = 0;
            key_in = 1'b0;
            for (int i = 0; i < 15; i++) begin
                tick();
                if (long_flag) lf_n++;
            end
            key_in = 1'b1;
            for (int i = 0; i < 20; i++) begin
                tick();
                if (long_flag) lf_n++;
            end
            check("short hold long count", lf_n, 0);
            check("short hold value", key_value, 1'b1);

            // Release bounce mid-hold keeps accumulating press time.
            lf_at = -1; lf_n = 0;
            for (int i = 1; i <= 60; i++) begin
                key_in = (i >= 21 && i <= 23) ? 1'b1 : 1'b0;
                tick();
                if (long_flag) begin lf_at = i; lf_n++; end
            end
            check("bounce long edge", lf_at, 30);
            check("bounce long count", lf_n, 1);
            check("bounce long value", key_value, 1'b0);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
